// File: rtl/upe_serial_sub64.sv
// Serial subtractor: Out = A - B (or -B) as A + ~B + 1, one SLICE_W-bit slice per cycle,
// least-significant slice first, with a registered carry between slices.
module upe_serial_sub64 #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             negate_only,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             borrow,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_n_q, opb_n_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               borrow_q, borrow_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready_s;
    logic               load_s;
    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W:0]   sum_s;

    // Next-state and datapath: one slice add per RUN cycle, operand load on accept
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_n_d     = opb_n_q;
        res_d       = res_q;
        out_d       = out_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        borrow_d    = borrow_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        // Held low during reset so no output reads as ready while the block is cleared
        in_ready_s = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        load_s     = in_valid && in_ready_s;

        slice_a_s = opa_q[idx_q*SLICE_W +: SLICE_W];
        slice_b_s = opb_n_q[idx_q*SLICE_W +: SLICE_W];
        sum_s     = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE_W{1'b0}}, carry_q};

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
            end
            ST_RUN: begin
                res_d[idx_q*SLICE_W +: SLICE_W] = sum_s[SLICE_W-1:0];
                carry_d = sum_s[SLICE_W];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d     = ST_DONE;
                    out_d       = res_d;
                    borrow_d    = ~sum_s[SLICE_W];
                    overflow_d  = (sign_a_q != sign_b_q) && (res_d[WIDTH-1] != sign_a_q);
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Accept overrides the case above; in DONE this is the same-edge consume-and-accept
        if (load_s) begin
            state_d     = ST_RUN;
            opa_d       = negate_only ? {WIDTH{1'b0}} : A;
            opb_n_d     = ~B;
            sign_a_d    = negate_only ? 1'b0 : A[WIDTH-1];
            sign_b_d    = B[WIDTH-1];
            carry_d     = 1'b1;
            idx_d       = {IDX_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            opa_d       = opa_d;
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opa_q       <= {WIDTH{1'b0}};
            opb_n_q     <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            carry_q     <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_n_q     <= opb_n_d;
            res_q       <= res_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            borrow_q    <= borrow_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;

endmodule
